// File: rtl/mux_n_to_1.sv
// N:1 single-bit multiplexer with a combinational result and an enable-loaded
// registered copy. Out-of-range indices yield a defined 0 and raise sel_err.
module mux_n_to_1 #(
  parameter int N = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic             out,
  output logic             sel_err,
  output logic             out_q,
  output logic             err_q
);

  // One extra bit so N itself is representable when N is a power of two.
  localparam logic [SEL_W:0] N_EXT = N[SEL_W:0];

  logic out_s;
  logic err_s;
  logic out_q_r;
  logic err_q_r;

  // Select by OR-reducing per-input matches so an out-of-range index never reads past in[N-1].
  always_comb begin
    out_s = 1'b0;
    err_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      out_s = out_s | (in[i] & (sel == SEL_W'(i)));
    end
    err_s = ~({1'b0, sel} < N_EXT);
  end

  // Output register: async clear, load on en, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_r <= 1'b0;
      err_q_r <= 1'b0;
    end else if (en) begin
      out_q_r <= out_s;
      err_q_r <= err_s;
    end else begin
      out_q_r <= out_q_r;
      err_q_r <= err_q_r;
    end
  end

  assign out     = out_s;
  assign sel_err = err_s;
  assign out_q   = out_q_r;
  assign err_q   = err_q_r;

endmodule

// File: tb/tb_mux_n_to_1.sv
// Self-checking bench for mux_n_to_1 at N=4, N=5 (non power of two) and N=8,
// with expected results queued at drive time and popped at observation time.
module tb_mux_n_to_1;

  typedef struct packed {
    logic o;
    logic e;
  } exp_t;

  logic clk;
  logic rst_n;
  logic en;

  logic [3:0] in4;
  logic [1:0] sel4;
  logic       out4, err4, out_q4, err_q4;

  logic [4:0] in5;
  logic [2:0] sel5;
  logic       out5, err5, out_q5, err_q5;

  logic [7:0] in8;
  logic [2:0] sel8;
  logic       out8, err8, out_q8, err_q8;

  exp_t sb[$];
  exp_t ex;
  int   compared;
  int   mismatched;

  mux_n_to_1 #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in(in4), .sel(sel4), .en(en),
    .out(out4), .sel_err(err4), .out_q(out_q4), .err_q(err_q4)
  );

  mux_n_to_1 #(.N(5)) u5 (
    .clk(clk), .rst_n(rst_n), .in(in5), .sel(sel5), .en(en),
    .out(out5), .sel_err(err5), .out_q(out_q5), .err_q(err_q5)
  );

  mux_n_to_1 #(.N(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel8), .en(en),
    .out(out8), .sel_err(err8), .out_q(out_q8), .err_q(err_q8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    rst_n = 1'b1;
    en    = 1'b0;
    in4 = 4'b0000; sel4 = 2'd0;
    in5 = 5'b00000; sel5 = 3'd0;
    in8 = 8'h00;  sel8 = 3'd0;
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_q4, err_q4, out_q5, err_q5, out_q8, err_q8} !== 6'b000000) begin
      mismatched++;
      $display("FAIL reset_regs: got %b expected 000000",
               {out_q4, err_q4, out_q5, err_q5, out_q8, err_q8});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_comb_select();
    logic exp_bits [4];
    exp_bits = '{1'b1, 1'b0, 1'b1, 1'b0};
    in4 = 4'b0101;
    for (int s = 0; s < 4; s++) begin
      sel4 = 2'(s);
      sb.push_back('{o: exp_bits[s], e: 1'b0});
      #1;
      ex = sb.pop_front();
      compared++;
      if ({out4, err4} !== {ex.o, ex.e}) begin
        mismatched++;
        $display("FAIL comb_sel%0d: got out/err=%b%b expected %b%b", s, out4, err4, ex.o, ex.e);
      end
      #9;
    end
  endtask

  task automatic test_register();
    @(negedge clk);
    en = 1'b1; in4 = 4'b0101; sel4 = 2'd1;
    sb.push_back('{o: 1'b0, e: 1'b0});
    @(posedge clk); #1;
    ex = sb.pop_front();
    compared++;
    if ({out_q4, err_q4} !== {ex.o, ex.e}) begin
      mismatched++;
      $display("FAIL reg_sel1: got %b%b expected %b%b", out_q4, err_q4, ex.o, ex.e);
    end
    sel4 = 2'd2;
    sb.push_back('{o: 1'b1, e: 1'b0});
    @(posedge clk); #1;
    ex = sb.pop_front();
    compared++;
    if ({out_q4, err_q4} !== {ex.o, ex.e}) begin
      mismatched++;
      $display("FAIL reg_sel2: got %b%b expected %b%b", out_q4, err_q4, ex.o, ex.e);
    end
  endtask

  task automatic test_hold();
    en = 1'b0; sel4 = 2'd1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      compared++;
      if ({out_q4, out4} !== 2'b10) begin
        mismatched++;
        $display("FAIL hold_cyc%0d: got out_q/out=%b%b expected 10", c, out_q4, out4);
      end
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_q4, err_q4} !== 2'b00) begin
      mismatched++;
      $display("FAIL async_reset: got %b%b expected 00", out_q4, err_q4);
    end
    sel4 = 2'd2;
    #1;
    compared++;
    if (out4 !== 1'b1) begin
      mismatched++;
      $display("FAIL comb_in_reset: got %b expected 1", out4);
    end
    @(posedge clk); #1;
    compared++;
    if (out_q4 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_overrides_en: got %b expected 0", out_q4);
    end
    @(negedge clk);
    en = 1'b1; rst_n = 1'b1;
    #1;
    compared++;
    if (out_q4 !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_first_capture: got %b expected 0", out_q4);
    end
    @(posedge clk); #1;
    compared++;
    if (out_q4 !== 1'b1) begin
      mismatched++;
      $display("FAIL first_capture: got %b expected 1", out_q4);
    end
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    en = 1'b0; in5 = 5'b10110; sel5 = 3'd4;
    #1;
    compared++;
    if ({out5, err5} !== 2'b10) begin
      mismatched++;
      $display("FAIL n5_sel4: got %b%b expected 10", out5, err5);
    end
    for (int s = 5; s < 8; s++) begin
      sel5 = 3'(s);
      #1;
      compared++;
      if ({out5, err5} !== 2'b01) begin
        mismatched++;
        $display("FAIL n5_sel%0d: got %b%b expected 01", s, out5, err5);
      end
    end
    en = 1'b1;
    @(posedge clk); #1;
    compared++;
    if ({out_q5, err_q5} !== 2'b01) begin
      mismatched++;
      $display("FAIL n5_err_q: got %b%b expected 01", out_q5, err_q5);
    end
  endtask

  task automatic test_walking_one();
    for (int h = 0; h < 8; h++) begin
      in8 = 8'h01 << h;
      for (int s = 0; s < 8; s++) begin
        sel8 = 3'(s);
        sb.push_back('{o: (s == h), e: 1'b0});
        #1;
        ex = sb.pop_front();
        compared++;
        if ({out8, err8} !== {ex.o, ex.e}) begin
          mismatched++;
          $display("FAIL walk_h%0d_s%0d: got %b%b expected %b%b", h, s, out8, err8, ex.o, ex.e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] v;
    logic [2:0] s;
    en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      v = 5'($urandom_range(0, 31));
      s = 3'($urandom_range(0, 7));
      in5 = v; sel5 = s;
      if (s < 3'd5) sb.push_back('{o: v[s], e: 1'b0});
      else          sb.push_back('{o: 1'b0, e: 1'b1});
      @(posedge clk); #1;
      ex = sb.pop_front();
      compared++;
      if ({out_q5, err_q5} !== {ex.o, ex.e}) begin
        mismatched++;
        $display("FAIL b2b_%0d in=%b sel=%0d: got %b%b expected %b%b",
                 k, v, s, out_q5, err_q5, ex.o, ex.e);
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_comb_select();
    test_register();
    test_hold();
    test_reset_mid();
    test_out_of_range();
    test_walking_one();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
